// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus host-side buffer/status signals of the SPI slave
interface spi_slave_if #(
  parameter int WORD_LEN = 8
);
  logic                sck;
  logic                ss;
  logic                mosi;
  logic                miso;
  logic                miso_oe;
  logic [1:0]          mode;
  logic                lsbfirst;
  logic [WORD_LEN-1:0] tx_data;
  logic                tx_wr;
  logic                tx_full;
  logic [WORD_LEN-1:0] rx_data;
  logic                rx_valid;
  logic                rx_rd;
  logic                overrun;
  logic                underrun;
  logic                wr_err;
  logic                res_err;
  logic                busy;

  modport slave (
    input  sck, ss, mosi, mode, lsbfirst, tx_data, tx_wr, rx_rd, res_err,
    output miso, miso_oe, tx_full, rx_data, rx_valid, overrun, underrun, wr_err, busy
  );

  modport master (
    output sck, ss, mosi, mode, lsbfirst, tx_data, tx_wr, rx_rd, res_err,
    input  miso, miso_oe, tx_full, rx_data, rx_valid, overrun, underrun, wr_err, busy
  );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: oversampling SPI slave, all four modes, MSB/LSB first, single-entry tx/rx buffers
module spi_slave #(
  parameter int WORD_LEN    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_slave_if.slave   io_bus
);
  localparam int CW = $clog2(WORD_LEN + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sck_sync, r_ss_sync, r_mosi_sync;
  logic                   r_sck_d, r_ss_d;
  logic                   r_cpol, r_cpha, r_lsb, r_skip;
  logic [CW-1:0]          r_bitcnt;
  logic [WORD_LEN-1:0]    r_shift_in, r_shift_out, r_tx_buf, r_rx_data;
  logic                   r_tx_full, r_rx_valid, r_overrun, r_underrun, r_wr_err;

  logic                w_sck, w_ss, w_mosi, w_sck_rise, w_sck_fall, w_ss_fall;
  logic                w_lead, w_trail, w_act, w_sample, w_shift, w_done, w_start, w_load;
  logic [CW-1:0]       w_cnt_inc;
  logic [WORD_LEN-1:0] w_word;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_ss       = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_ss_fall  = ~w_ss & r_ss_d;
  assign w_lead     = r_cpol ? w_sck_fall : w_sck_rise;
  assign w_trail    = r_cpol ? w_sck_rise : w_sck_fall;
  assign w_act      = (r_state == ACTIVE) && !w_ss;
  assign w_sample   = w_act && (r_cpha ? w_trail : w_lead);
  assign w_shift    = w_act && (r_cpha ? w_lead : w_trail);
  assign w_cnt_inc  = r_bitcnt + 1'b1;
  assign w_done     = w_sample && (w_cnt_inc == CW'(WORD_LEN));
  assign w_start    = (r_state == IDLE) && w_ss_fall;
  assign w_load     = w_start | w_done;
  assign w_word     = r_lsb ? {w_mosi, r_shift_in[WORD_LEN-1:1]}
                            : {r_shift_in[WORD_LEN-2:0], w_mosi};

  assign io_bus.tx_full  = r_tx_full;
  assign io_bus.rx_data  = r_rx_data;
  assign io_bus.rx_valid = r_rx_valid;
  assign io_bus.overrun  = r_overrun;
  assign io_bus.underrun = r_underrun;
  assign io_bus.wr_err   = r_wr_err;

  // Input synchronizers plus one delay flop for edge detection; ss idles high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sck_sync  <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], io_bus.sck};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], io_bus.ss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], io_bus.mosi};
      r_sck_d     <= w_sck;
      r_ss_d      <= w_ss;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next state: select falling enters ACTIVE, deselect level drops back to IDLE
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_ss_fall ? ACTIVE : IDLE;
    else                 w_next = w_ss ? IDLE : ACTIVE;
  end

  // Outputs: miso is only driven while selected
  always_comb begin
    io_bus.busy    = (r_state == ACTIVE);
    io_bus.miso_oe = (r_state == ACTIVE);
    io_bus.miso    = (r_state == ACTIVE) &&
                     (r_lsb ? r_shift_out[0] : r_shift_out[WORD_LEN-1]);
  end

  // Shift engine; r_skip suppresses the shift edge that directly follows a load
  // so the freshly loaded first bit stays on miso until the master samples it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_lsb       <= 1'b0;
      r_skip      <= 1'b0;
      r_bitcnt    <= '0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
    end else begin
      if (w_start) begin
        r_cpol <= io_bus.mode[1];
        r_cpha <= io_bus.mode[0];
        r_lsb  <= io_bus.lsbfirst;
      end
      if (w_load)        r_bitcnt <= '0;
      else if (w_sample) r_bitcnt <= w_cnt_inc;
      if (w_start)       r_shift_in <= '0;
      else if (w_sample) r_shift_in <= w_word;
      if (w_load)       r_skip <= w_done | io_bus.mode[0];
      else if (w_shift) r_skip <= 1'b0;
      if (w_load)                 r_shift_out <= r_tx_full ? r_tx_buf : '1;
      else if (w_shift && !r_skip) r_shift_out <= r_lsb ? {1'b0, r_shift_out[WORD_LEN-1:1]}
                                                        : {r_shift_out[WORD_LEN-2:0], 1'b0};
    end
  end

  // Host-side buffers and sticky flags; setting events beat res_err and rx_rd
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_buf   <= '0;
      r_tx_full  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      if (io_bus.tx_wr && !r_tx_full) begin
        r_tx_buf  <= io_bus.tx_data;
        r_tx_full <= 1'b1;
      end else if (w_load && r_tx_full) begin
        r_tx_full <= 1'b0;
      end
      if (w_done) r_rx_data <= w_word;
      r_rx_valid <= w_done | (r_rx_valid & ~io_bus.rx_rd);
      r_overrun  <= (w_done & r_rx_valid & ~io_bus.rx_rd) | (r_overrun & ~io_bus.res_err);
      r_underrun <= (w_load & ~r_tx_full) | (r_underrun & ~io_bus.res_err);
      r_wr_err   <= (io_bus.tx_wr & r_tx_full) | (r_wr_err & ~io_bus.res_err);
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: SPI master model with scoreboard queues for received and returned words
module tb_spi_slave;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_slave_if #(.WORD_LEN(8)) bus ();

  spi_slave #(.WORD_LEN(8), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] q_rx[$];
  logic [7:0] q_miso[$];
  logic       cpol, cpha, lsb;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic l);
    cpol = pol; cpha = pha; lsb = l;
    bus.mode = {pol, pha};
    bus.lsbfirst = l;
    bus.sck = pol;
    tick(4);
  endtask

  task automatic ss_low();
    bus.ss = 1'b0;
    tick(HALF);
  endtask

  task automatic ss_high();
    tick(HALF);
    bus.ss = 1'b1;
    tick(HALF);
  endtask

  task automatic pulse_tx(input logic [7:0] d);
    bus.tx_data = d;
    bus.tx_wr = 1'b1;
    tick(1);
    bus.tx_wr = 1'b0;
  endtask

  task automatic pulse_rd();
    bus.rx_rd = 1'b1;
    tick(1);
    bus.rx_rd = 1'b0;
  endtask

  task automatic pulse_res();
    bus.res_err = 1'b1;
    tick(1);
    bus.res_err = 1'b0;
  endtask

  // Master shifts nbits of tx; full words are scored against the expected queues
  task automatic xfer(input logic [7:0] tx, input int nbits, input logic [7:0] miso_exp);
    logic [7:0] got, exp_w;
    int k, t;
    got = '0;
    if (nbits == 8) begin
      q_rx.push_back(tx);
      q_miso.push_back(miso_exp);
    end
    for (int i = 0; i < nbits; i++) begin
      k = lsb ? i : 7 - i;
      if (!cpha) begin
        bus.mosi = tx[k];
        tick(HALF);
        got[k] = bus.miso;
        bus.sck = ~cpol;
        tick(HALF);
        bus.sck = cpol;
      end else begin
        bus.sck = ~cpol;
        bus.mosi = tx[k];
        tick(HALF);
        got[k] = bus.miso;
        bus.sck = cpol;
        tick(HALF);
      end
    end
    if (nbits == 8) begin
      t = 0;
      while (!bus.rx_valid && t < 16) begin
        tick(1);
        t++;
      end
      n_cmp++;
      if (bus.rx_valid !== 1'b1) begin
        n_err++;
        $display("FAIL rx_valid_wait: got %b want 1", bus.rx_valid);
      end
      exp_w = q_rx.pop_front();
      n_cmp++;
      if (bus.rx_data !== exp_w) begin
        n_err++;
        $display("FAIL rx_data: got %h want %h", bus.rx_data, exp_w);
      end
      exp_w = q_miso.pop_front();
      n_cmp++;
      if (got !== exp_w) begin
        n_err++;
        $display("FAIL miso_word: got %h want %h", got, exp_w);
      end
    end
  endtask

  task automatic test_reset();
    bus.ss = 1'b1; bus.sck = 1'b0; bus.mosi = 1'b0; bus.mode = 2'b00; bus.lsbfirst = 1'b0;
    bus.tx_data = '0; bus.tx_wr = 1'b0; bus.rx_rd = 1'b0; bus.res_err = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
    tick(3);
    n_cmp++;
    if ({bus.miso, bus.miso_oe, bus.tx_full, bus.rx_valid, bus.overrun, bus.underrun, bus.wr_err, bus.busy} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 00000000",
               {bus.miso, bus.miso_oe, bus.tx_full, bus.rx_valid, bus.overrun, bus.underrun, bus.wr_err, bus.busy});
    end
    n_cmp++;
    if (bus.rx_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_rx_data: got %h want 00", bus.rx_data);
    end
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_mode0_msb();
    set_mode(1'b0, 1'b0, 1'b0);
    pulse_tx(8'h3C);
    n_cmp++;
    if (bus.tx_full !== 1'b1) begin
      n_err++;
      $display("FAIL t1_tx_full_before: got %b want 1", bus.tx_full);
    end
    ss_low();
    n_cmp++;
    if (bus.tx_full !== 1'b0) begin
      n_err++;
      $display("FAIL t1_tx_full_after_load: got %b want 0", bus.tx_full);
    end
    n_cmp++;
    if ({bus.busy, bus.miso_oe} !== 2'b11) begin
      n_err++;
      $display("FAIL t1_active: got %b want 11", {bus.busy, bus.miso_oe});
    end
    xfer(8'hA5, 8, 8'h3C);
    ss_high();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL t1_busy_idle: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_mode3_lsb();
    pulse_rd();
    pulse_res();
    set_mode(1'b1, 1'b1, 1'b1);
    pulse_tx(8'h81);
    ss_low();
    pulse_tx(8'h42);
    xfer(8'h0F, 8, 8'h81);
    n_cmp++;
    if ({bus.overrun, bus.underrun, bus.wr_err} !== 3'b000) begin
      n_err++;
      $display("FAIL t2_flags_mid: got %b want 000", {bus.overrun, bus.underrun, bus.wr_err});
    end
    n_cmp++;
    if (bus.tx_full !== 1'b0) begin
      n_err++;
      $display("FAIL t2_tx_full: got %b want 0", bus.tx_full);
    end
    pulse_rd();
    xfer(8'hF0, 8, 8'h42);
    ss_high();
    n_cmp++;
    if ({bus.overrun, bus.wr_err} !== 2'b00) begin
      n_err++;
      $display("FAIL t2_flags_end: got %b want 00", {bus.overrun, bus.wr_err});
    end
  endtask

  task automatic test_underrun();
    pulse_res();
    set_mode(1'b0, 1'b1, 1'b0);
    ss_low();
    xfer(8'h55, 8, 8'hFF);
    ss_high();
    n_cmp++;
    if (bus.underrun !== 1'b1) begin
      n_err++;
      $display("FAIL t3_underrun_set: got %b want 1", bus.underrun);
    end
    pulse_res();
    n_cmp++;
    if (bus.underrun !== 1'b0) begin
      n_err++;
      $display("FAIL t3_underrun_clr: got %b want 0", bus.underrun);
    end
  endtask

  task automatic test_overrun_wr_err();
    pulse_rd();
    set_mode(1'b0, 1'b0, 1'b0);
    ss_low();
    xfer(8'h11, 8, 8'hFF);
    xfer(8'h22, 8, 8'hFF);
    ss_high();
    n_cmp++;
    if (bus.overrun !== 1'b1) begin
      n_err++;
      $display("FAIL t4_overrun: got %b want 1", bus.overrun);
    end
    n_cmp++;
    if (bus.rx_data !== 8'h22) begin
      n_err++;
      $display("FAIL t4_rx_last: got %h want 22", bus.rx_data);
    end
    pulse_tx(8'h99);
    pulse_tx(8'h66);
    n_cmp++;
    if ({bus.wr_err, bus.tx_full} !== 2'b11) begin
      n_err++;
      $display("FAIL t4_wr_err: got %b want 11", {bus.wr_err, bus.tx_full});
    end
    pulse_res();
    n_cmp++;
    if ({bus.wr_err, bus.overrun} !== 2'b00) begin
      n_err++;
      $display("FAIL t4_res_err: got %b want 00", {bus.wr_err, bus.overrun});
    end
  endtask

  task automatic test_abort();
    pulse_rd();
    set_mode(1'b0, 1'b0, 1'b0);
    ss_low();
    xfer(8'h5A, 3, 8'h00);
    bus.ss = 1'b1;
    tick(HALF);
    n_cmp++;
    if (bus.rx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL t5_rx_valid: got %b want 0", bus.rx_valid);
    end
    n_cmp++;
    if ({bus.busy, bus.miso_oe} !== 2'b00) begin
      n_err++;
      $display("FAIL t5_idle: got %b want 00", {bus.busy, bus.miso_oe});
    end
    ss_low();
    xfer(8'hC3, 8, 8'hFF);
    ss_high();
  endtask

  task automatic test_async_reset();
    set_mode(1'b0, 1'b0, 1'b0);
    ss_low();
    pulse_tx(8'h77);
    xfer(8'hFF, 4, 8'h00);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.miso, bus.miso_oe, bus.tx_full, bus.rx_valid, bus.overrun, bus.underrun, bus.wr_err, bus.busy} !== 8'h00) begin
      n_err++;
      $display("FAIL t6_reset_flags: got %b want 00000000",
               {bus.miso, bus.miso_oe, bus.tx_full, bus.rx_valid, bus.overrun, bus.underrun, bus.wr_err, bus.busy});
    end
    n_cmp++;
    if (bus.rx_data !== 8'h00) begin
      n_err++;
      $display("FAIL t6_reset_rx_data: got %h want 00", bus.rx_data);
    end
    bus.ss = 1'b1;
    bus.sck = 1'b0;
    tick(3);
    n_cmp++;
    if ({bus.busy, bus.tx_full} !== 2'b00) begin
      n_err++;
      $display("FAIL t6_held_reset: got %b want 00", {bus.busy, bus.tx_full});
    end
    rst = 1'b1;
    tick(2);
    ss_low();
    xfer(8'h7E, 8, 8'hFF);
    ss_high();
  endtask

  initial begin
    test_reset();
    test_mode0_msb();
    test_mode3_lsb();
    test_underrun();
    test_overrun_wr_err();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
